poly_coef_packer: RTL and testbench
===================================

// Module: poly_coef_packer
// PURPOSE
//  Upstream loader for the NTT/INTT/MULT processor. Accepts one 12-bit coefficient per
//  valid/ready beat and reduces it once mod q = 3329. Packs 8 reduced coefficients into
//  one 96-bit word. Writes 32 consecutive words (one 256-coef polynomial) into the polynomial
//  RAM that the processor reads via r_data / r_start_offset_A/B.
//  Pulses done when the polynomial is resident, so the controller can raise the processor's start.
// PARAMETERS
//  COEF_W  12    coefficient width (bits)
//  LANES   8     coefficients per packed word
//  WORDS   32    words per polynomial (LANES*WORDS = 256 coefficients)
//  ADDR_W  8     RAM word-address width
//  Q       3329  Kyber modulus, used for the single conditional subtraction
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        synchronous active-high reset
//  load_req   in   1        start a polynomial load (sampled in IDLE only)
//  base_addr  in   ADDR_W   first word address; captured when load_req is accepted
//  abort      in   1        cancel the current load
//  in_valid   in   1        coefficient beat valid
//  in_data    in   COEF_W   raw coefficient, 0..4095
//  in_ready   out  1        block can accept a beat this cycle
//  mem_wen    out  1        RAM write strobe, one cycle per word
//  mem_waddr  out  ADDR_W   RAM word address
//  mem_wdata  out  96       packed word; lane i occupies bits [12i+11:12i]
//  busy       out  1        load in progress
//  done       out  1        one-cycle pulse: all 32 words written
// BEHAVIOUR
//  Reset (rst=1 at an edge, any state):
//   - state=IDLE; all outputs 0.
//   - Lane, word and base registers cleared; a partial word is discarded and never written.
//  Beat acceptance: a beat is accepted when in_valid & in_ready.
//   - in_ready = (state==FILL); it does not depend combinationally on in_valid.
//  Reduction: c' = (in_data >= Q) ? in_data - Q : in_data, so c' is always in 0..3328.
//  Packing:
//   - Lane counter 0..7; the first beat of each word goes to lane 0.
//   - On the beat accepted into lane 7 at edge t, edge t+1 registers:
//     mem_wen=1, mem_wdata = full word (including that beat), mem_waddr = base + word_idx (mod 2^ADDR_W).
//   - word_idx then increments. mem_wen is 0 in every other cycle.
//   - Full throughput: in_ready stays high during write cycles (one beat/cycle sustained).
//  FSM:
//   - IDLE: load_req=1 -> FILL; base captured, lane=word=0, busy=1 from the next cycle.
//   - FILL: 256th accepted beat -> DRAIN.
//   - DRAIN: in_ready=0; the last word write (word 31) is on mem_wen this cycle -> IDLE.
//     On entry to IDLE, done=1 for exactly one cycle and busy=0 in that same cycle.
//  Latency: last beat accepted at edge t -> word 31 written in cycle t+1 -> done=1 in cycle t+2.
//  Boundary rules:
//   - load_req while busy is ignored; base_addr changes while busy are ignored.
//   - abort has priority over load_req and over a lane-7 accept in the same cycle. In FILL or
//     DRAIN: next state IDLE; next cycle mem_wen=0, busy=0, done=0; the partial word is dropped.
//   - abort in IDLE is ignored; load_req in the same cycle is still accepted.
//   - Address wrap: base+word_idx wraps modulo 256 (e.g. base 0xF0 -> ...0xFF, 0x00...).
//   - in_data/in_valid while in_ready=0 are ignored; there is no buffering beyond the current word.
// TESTING
//  1. rst; load_req, base=0x40; stream 0..255 with in_valid held high ->
//     32 writes to 0x40..0x5F; word0 = {12'd7,...,12'd1,12'd0}; done exactly 2 cycles after the last accept.
//  2. Beats 3328, 3329, 4095, 0, 1, 2, 3, 4 ->
//     word0 lanes 0..7 = 3328, 0, 766, 0, 1, 2, 3, 4.
//  3. in_valid toggled every other cycle, data 0..255 ->
//     identical words and addresses to test 1; no write cycle without a completed word.
//  4. base=0xF0, full load -> addresses 0xF0..0xFF then 0x00..0x0F; done pulses once.
//  5. abort after 100 accepted beats -> exactly 12 writes seen; busy=0 next cycle; no done;
//     a following load_req (base=0x00) completes normally with a fresh lane 0.
//  6. rst asserted mid-FILL -> all outputs 0 next cycle; load_req pulsed while busy ->
//     ignored (base unchanged, the run still ends with exactly one done).

Source files
------------

// File: rtl/poly_coef_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : poly_coef_packer_if
// Brief    : Load-control, coefficient stream and RAM-write bundle of the packer.
// Revision : 1.0  initial release
// ============================================================================
interface poly_coef_packer_if #(
    parameter int COEF_W = 12,
    parameter int LANES  = 8,
    parameter int ADDR_W = 8
);
    logic                      load_req;
    logic [ADDR_W-1:0]         base_addr;
    logic                      abort;
    logic                      in_valid;
    logic [COEF_W-1:0]         in_data;
    logic                      in_ready;
    logic                      mem_wen;
    logic [ADDR_W-1:0]         mem_waddr;
    logic [LANES*COEF_W-1:0]   mem_wdata;
    logic                      busy;
    logic                      done;

    modport master (
        output load_req, base_addr, abort, in_valid, in_data,
        input  in_ready, mem_wen, mem_waddr, mem_wdata, busy, done
    );

    modport slave (
        input  load_req, base_addr, abort, in_valid, in_data,
        output in_ready, mem_wen, mem_waddr, mem_wdata, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/poly_coef_packer.sv
`default_nettype none
// ============================================================================
// Module   : poly_coef_packer
// Brief    : Reduces coefficients mod Q, packs LANES per word, writes one polynomial.
// Revision : 1.0  initial release
// ============================================================================
module poly_coef_packer #(
    parameter int COEF_W = 12,
    parameter int LANES  = 8,
    parameter int WORDS  = 32,
    parameter int ADDR_W = 8,
    parameter int Q      = 3329
) (
    input  logic              clk,
    input  logic              rst,
    poly_coef_packer_if.slave bus
);
    localparam int c_lane_w = $clog2(LANES);
    localparam int c_word_w = $clog2(WORDS);
    localparam int c_data_w = LANES * COEF_W;
    localparam logic [COEF_W-1:0]   c_q         = COEF_W'(Q);
    localparam logic [c_lane_w-1:0] c_last_lane = c_lane_w'(LANES - 1);
    localparam logic [c_word_w-1:0] c_last_word = c_word_w'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_in_ready;
    logic                  w_start;
    logic                  w_abort;
    logic                  w_done_nxt;
    logic                  w_accept;
    logic                  w_last_lane;
    logic [COEF_W-1:0]     w_coef;
    logic [c_data_w-1:0]   w_word;

    logic [c_data_w-1:0]   r_word;
    logic [c_lane_w-1:0]   r_lane;
    logic [c_word_w-1:0]   r_word_idx;
    logic [ADDR_W-1:0]     r_base;
    logic                  r_mem_wen;
    logic [ADDR_W-1:0]     r_mem_waddr;
    logic [c_data_w-1:0]   r_mem_wdata;
    logic                  r_done;

    assign w_last_lane = (r_lane == c_last_lane);

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // abort outranks both a new request and the final lane-7 beat
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_start     = 1'b0;
        w_abort     = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.load_req) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                w_in_ready = 1'b1;
                if (bus.abort) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (bus.in_valid && w_last_lane && (r_word_idx == c_last_word)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_IDLE;
                if (bus.abort) w_abort    = 1'b1;
                else           w_done_nxt = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_accept = w_in_ready & bus.in_valid & ~bus.abort;

    // single conditional subtraction suffices since inputs are below 2*Q
    always_comb begin
        w_coef = (bus.in_data >= c_q) ? (bus.in_data - c_q) : bus.in_data;
        w_word = r_word;
        w_word[int'(r_lane)*COEF_W +: COEF_W] = w_coef;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word      <= '0;
            r_lane      <= '0;
            r_word_idx  <= '0;
            r_base      <= '0;
            r_mem_wen   <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
        end else begin
            r_mem_wen <= 1'b0;
            r_done    <= w_done_nxt;
            if (w_start) begin
                r_base     <= bus.base_addr;
                r_lane     <= '0;
                r_word_idx <= '0;
            end else if (w_abort) begin
                r_lane     <= '0;
                r_word_idx <= '0;
            end else if (w_accept) begin
                r_word <= w_word;
                if (w_last_lane) begin
                    r_lane      <= '0;
                    r_word_idx  <= r_word_idx + 1'b1;
                    r_mem_wen   <= 1'b1;
                    r_mem_wdata <= w_word;
                    r_mem_waddr <= r_base + ADDR_W'(r_word_idx);
                end else begin
                    r_lane <= r_lane + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.mem_wen   = r_mem_wen;
    assign bus.mem_waddr = r_mem_waddr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.done      = r_done;
endmodule
`default_nettype wire

// File: tb/tb_poly_coef_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_poly_coef_packer
// Brief    : Directed bench for poly_coef_packer with hand-computed expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_poly_coef_packer;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   done_cnt;
    logic [11:0] beats [256];
    logic [7:0]  wr_addr_q [$];
    logic [95:0] wr_data_q [$];

    poly_coef_packer_if #(.COEF_W(12), .LANES(8), .ADDR_W(8)) bus ();

    poly_coef_packer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // write/done monitor, sampled 1 ns after each rising edge
    always begin
        @(posedge clk);
        #1;
        if (bus.mem_wen) begin
            wr_addr_q.push_back(bus.mem_waddr);
            wr_data_q.push_back(bus.mem_wdata);
        end
        if (bus.done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] red(input logic [11:0] x);
        return (x >= 12'd3329) ? x - 12'd3329 : x;
    endfunction

    function automatic logic [95:0] exp_word(input int w);
        logic [95:0] r;
        r = '0;
        for (int l = 0; l < 8; l++) r[12*l +: 12] = red(beats[8*w + l]);
        return r;
    endfunction

    task automatic start_load(input logic [7:0] base, input bit idle_abort);
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt = 0;
        bus.load_req  = 1'b1;
        bus.base_addr = base;
        bus.abort     = idle_abort;
        @(negedge clk);
        bus.load_req = 1'b0;
        bus.abort    = 1'b0;
        chk("start_busy", {95'd0, bus.busy}, 96'd1);
        chk("start_ready", {95'd0, bus.in_ready}, 96'd1);
    endtask

    task automatic stream(input int n, input bit toggle, input int pulse_at);
        int  k;
        int  cyc;
        bit  acc;
        k   = 0;
        cyc = 0;
        while (k < n && cyc < 3000) begin
            bus.in_valid = toggle ? ~cyc[0] : 1'b1;
            bus.in_data  = beats[k];
            bus.load_req = (k == pulse_at);
            if (k == pulse_at) bus.base_addr = 8'h00;
            acc = bus.in_valid && bus.in_ready;
            @(negedge clk);
            if (acc) k++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.load_req = 1'b0;
        if (k < n) chk("stream_timeout", 96'(k), 96'(n));
    endtask

    // entered at the falling edge just after the 256th beat was accepted
    task automatic finish_check(input string tag, input logic [7:0] base);
        logic [7:0] a;
        chk({tag, "_last_wen"}, {95'd0, bus.mem_wen}, 96'd1);
        chk({tag, "_last_addr"}, {88'd0, bus.mem_waddr}, {88'd0, 8'(base + 8'd31)});
        chk({tag, "_drain_ready"}, {95'd0, bus.in_ready}, 96'd0);
        chk({tag, "_done_early"}, {95'd0, bus.done}, 96'd0);
        @(negedge clk);
        chk({tag, "_done"}, {95'd0, bus.done}, 96'd1);
        chk({tag, "_busy_at_done"}, {95'd0, bus.busy}, 96'd0);
        chk({tag, "_wen_at_done"}, {95'd0, bus.mem_wen}, 96'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {95'd0, bus.done}, 96'd0);
        repeat (3) @(negedge clk);
        chk({tag, "_write_count"}, 96'(wr_addr_q.size()), 96'd32);
        chk({tag, "_done_count"}, 96'(done_cnt), 96'd1);
        for (int w = 0; w < 32 && w < wr_addr_q.size(); w++) begin
            a = base + 8'(w);
            chk({tag, "_addr"}, {88'd0, wr_addr_q[w]}, {88'd0, a});
            chk({tag, "_data"}, wr_data_q[w], exp_word(w));
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        done_cnt = 0;
        rst = 1'b1;
        bus.load_req  = 1'b0;
        bus.base_addr = 8'h00;
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 12'd0;
        for (int i = 0; i < 256; i++) beats[i] = 12'(i);
        repeat (3) @(negedge clk);
        chk("rst_ready", {95'd0, bus.in_ready}, 96'd0);
        chk("rst_busy", {95'd0, bus.busy}, 96'd0);
        chk("rst_done", {95'd0, bus.done}, 96'd0);
        chk("rst_wen", {95'd0, bus.mem_wen}, 96'd0);
        chk("rst_wdata", bus.mem_wdata, 96'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: straight load of 0..255 at 0x40
        start_load(8'h40, 1'b0);
        stream(256, 1'b0, -1);
        finish_check("t1", 8'h40);
        if (wr_data_q.size() > 0)
            chk("t1_word0", wr_data_q[0], 96'h007006005004003002001000);

        // 2: reduction corner values in the first word
        beats[0] = 12'd3328; beats[1] = 12'd3329; beats[2] = 12'd4095; beats[3] = 12'd0;
        beats[4] = 12'd1;    beats[5] = 12'd2;    beats[6] = 12'd3;    beats[7] = 12'd4;
        start_load(8'h00, 1'b0);
        stream(256, 1'b0, -1);
        finish_check("t2", 8'h00);
        if (wr_data_q.size() > 0)
            chk("t2_word0", wr_data_q[0],
                {12'd4, 12'd3, 12'd2, 12'd1, 12'd0, 12'd766, 12'd0, 12'd3328});
        for (int i = 0; i < 8; i++) beats[i] = 12'(i);

        // 3: valid toggled every other cycle
        start_load(8'h40, 1'b0);
        stream(256, 1'b1, -1);
        finish_check("t3", 8'h40);

        // 4: address wrap; abort in IDLE alongside load_req must not block the load
        start_load(8'hF0, 1'b1);
        stream(256, 1'b0, -1);
        finish_check("t4", 8'hF0);

        // 5: abort after 100 beats, with a beat offered in the same cycle
        start_load(8'h10, 1'b0);
        stream(100, 1'b0, -1);
        bus.abort    = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        chk("t5_busy", {95'd0, bus.busy}, 96'd0);
        chk("t5_wen", {95'd0, bus.mem_wen}, 96'd0);
        chk("t5_done", {95'd0, bus.done}, 96'd0);
        chk("t5_ready", {95'd0, bus.in_ready}, 96'd0);
        repeat (4) @(negedge clk);
        chk("t5_writes", 96'(wr_addr_q.size()), 96'd12);
        chk("t5_no_done", 96'(done_cnt), 96'd0);
        if (wr_addr_q.size() > 0)
            chk("t5_last_addr", {88'd0, wr_addr_q[wr_addr_q.size()-1]}, 96'h1B);
        start_load(8'h00, 1'b0);
        stream(256, 1'b0, -1);
        finish_check("t5b", 8'h00);

        // 6: reset mid-FILL, then a load with a stray load_req while busy
        start_load(8'h20, 1'b0);
        stream(50, 1'b0, -1);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("t6_rst_busy", {95'd0, bus.busy}, 96'd0);
        chk("t6_rst_ready", {95'd0, bus.in_ready}, 96'd0);
        chk("t6_rst_wen", {95'd0, bus.mem_wen}, 96'd0);
        chk("t6_rst_waddr", {88'd0, bus.mem_waddr}, 96'd0);
        chk("t6_rst_wdata", bus.mem_wdata, 96'd0);
        chk("t6_rst_done", {95'd0, bus.done}, 96'd0);
        rst = 1'b0;
        @(negedge clk);
        start_load(8'h80, 1'b0);
        stream(256, 1'b0, 60);
        finish_check("t6", 8'h80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
